// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned fetch requests with at most one outstanding, buffers
// returned words in a 2-entry FIFO for decode, and handles redirects from
// execute by flushing the buffer and discarding any in-flight response.
//
// Handshake semantics (all interfaces):
//   A request is accepted in a cycle where imem_req_valid && imem_req_ready.
//   A response is a single-cycle pulse on imem_rsp_valid; it is never stalled.
//   Decode consumes the FIFO head in a cycle where if_valid && id_ready.
//   redirect_valid wins over everything else in its cycle: no push, no pop,
//   and no request is offered.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  // Low address bits of the redirect target carry no information.
  assign w_unused      = &{1'b0, redirect_pc[1:0]};
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  assign w_empty = (r_count == 2'd0);
  assign w_full  = (r_count == 2'd2);

  // Request is offered only from REQ, with room in the buffer and no redirect.
  // rst_n gating keeps the request low while reset is held.
  assign w_req_valid = rst_n && (r_state == S_REQ) && !w_full && !redirect_valid;
  assign w_req_fire  = w_req_valid && imem_req_ready;

  // Pop uses the registered head; a redirect cancels it.
  assign w_pop  = !w_empty && id_ready && !redirect_valid;

  // A WAIT response enters the buffer unless a redirect kills it; a push at
  // full is only possible together with a pop (the request gate prevents it
  // otherwise), and the guard keeps the buffer from ever overflowing.
  assign w_push = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid &&
                  (!w_full || w_pop);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;

  // Head of the buffer drives decode directly; NOP and pc 0 when empty.
  assign if_valid = !w_empty;
  assign if_instr = w_empty ? NOP_INSTR : r_buf_instr[r_rd_ptr];
  assign if_pc    = w_empty ? 32'h0000_0000 : r_buf_pc[r_rd_ptr];

  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one request in flight, DROP swallows a cancelled response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // A response in the redirect cycle is discarded and ends the wait.
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // Fetch PC advances on acceptance and is reloaded on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_req_fire) begin
        r_out_pc <= r_fetch_pc;
      end
    end
  end

  // Two-entry ring buffer; redirect flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]    <= 32'h0000_0000;
        r_buf_instr[i] <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_pc[r_wr_ptr]    <= r_out_pc;
        r_buf_instr[r_wr_ptr] <= imem_rsp_data;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the fetch front end.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus controls
  logic        drv_ready, drv_redirect, drv_id_ready, drv_stale;
  logic [31:0] drv_tgt;
  int          lat_min, lat_max;

  // Memory model
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;

  // Behavioural model: buffered entries as queues, one in-flight flag
  logic [31:0] exp_q[$];
  logic [31:0] exp_iq[$];
  logic [31:0] m_pc, m_out;
  logic        m_busy, m_drop;

  // Logs and per-cycle samples
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_ilog[$];
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_iq.delete();
    m_pc   = RESET_PC;
    m_out  = RESET_PC;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic set_idle();
    drv_ready = 1'b0; drv_redirect = 1'b0; drv_id_ready = 1'b0;
    drv_stale = 1'b0; drv_tgt = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
  endtask

  // Driver: reset asserted mid-cycle, outputs checked while held
  task automatic do_reset();
    @(posedge clk);
    #3;
    set_idle();
    rst_n = 1'b0;
    #1;
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_if_valid",  32'(if_valid), 32'd0);
    check32("rst_if_instr",  if_instr, NOP);
    check32("rst_if_pc",     if_pc, 32'h0);
    model_reset();
    mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Driver + compare + model update for one clock cycle
  task automatic cycle();
    logic exp_req_valid, fire_m, dut_fire, rsp;
    @(posedge clk);
    #1;
    imem_req_ready = drv_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_tgt;
    id_ready       = drv_id_ready;
    if (mem_busy && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else if (drv_stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_instr  = if_instr;
    rsp         = imem_rsp_valid;

    // Compare against the model
    exp_req_valid = !m_busy && (exp_q.size() < 2) && !drv_redirect;
    check32("req_valid", 32'(s_req_valid), 32'(exp_req_valid));
    if (exp_req_valid) check32("req_addr", s_req_addr, m_pc);
    check32("if_valid", 32'(s_if_valid), 32'(exp_q.size() != 0));
    check32("if_pc",    s_if_pc,    (exp_q.size() != 0) ? exp_q[0]  : 32'h0);
    check32("if_instr", s_if_instr, (exp_q.size() != 0) ? exp_iq[0] : NOP);

    // Logs of what the DUT did
    dut_fire = s_req_valid && drv_ready;
    if (dut_fire) req_log.push_back(s_req_addr);
    if (s_if_valid && drv_id_ready && !drv_redirect) begin
      pop_log.push_back(s_if_pc);
      pop_ilog.push_back(s_if_instr);
    end

    // Model update for the coming edge
    fire_m = exp_req_valid && drv_ready;
    if (drv_redirect) begin
      exp_q.delete();
      exp_iq.delete();
      m_pc = {drv_tgt[31:2], 2'b00};
      if (m_busy && !rsp) m_drop = 1'b1;
      else m_busy = 1'b0;
    end else begin
      if (exp_q.size() != 0 && drv_id_ready) begin
        void'(exp_q.pop_front());
        void'(exp_iq.pop_front());
      end
      if (m_busy && rsp) begin
        if (!m_drop) begin
          exp_q.push_back(m_out);
          exp_iq.push_back(imem_rsp_data);
        end
        m_busy = 1'b0;
      end
      if (fire_m) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_out  = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end

    // Memory update
    if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (dut_fire) begin
      mem_busy = 1'b1;
      mem_addr = s_req_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
    pop_ilog.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
    lat_min = 1; lat_max = 1;
    model_reset();

    // Straight-line fetch with 1-cycle memory
    do_reset();
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    clear_logs();
    run(7);
    check32("a_nreq", req_log.size(), 4);
    check32("a_npop", pop_log.size(), 3);
    if (req_log.size() >= 3 && pop_log.size() >= 3) begin
      check32("a_req0", req_log[0], 32'h0);
      check32("a_req1", req_log[1], 32'h4);
      check32("a_req2", req_log[2], 32'h8);
      check32("a_pop0", pop_log[0], 32'h0);
      check32("a_pop1", pop_log[1], 32'h4);
      check32("a_pop2", pop_log[2], 32'h8);
      check32("a_ins0", pop_ilog[0], 32'hC0DE_0001);
      check32("a_ins1", pop_ilog[1], 32'hC0DA_0001);
    end

    // Decode stalled: buffer fills to two, then drains without loss
    do_reset();
    drv_ready = 1'b1; drv_id_ready = 1'b0;
    run(6);
    check32("b_req_blocked", 32'(s_req_valid), 32'd0);
    check32("b_if_valid", 32'(s_if_valid), 32'd1);
    check32("b_head_pc", s_if_pc, 32'h0);
    clear_logs();
    drv_id_ready = 1'b1;
    run(6);
    check32("b_npop", pop_log.size(), 4);
    if (pop_log.size() >= 3) begin
      check32("b_pop0", pop_log[0], 32'h0);
      check32("b_pop1", pop_log[1], 32'h4);
      check32("b_pop2", pop_log[2], 32'h8);
    end

    // Redirect while a request is outstanding
    do_reset();
    lat_min = 2; lat_max = 2;
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    run(1);
    clear_logs();
    drv_redirect = 1'b1; drv_tgt = 32'h0000_0103;
    run(1);
    check32("c_req_in_redirect", 32'(s_req_valid), 32'd0);
    drv_redirect = 1'b0;
    run(1);
    check32("c_drop_if_valid", 32'(s_if_valid), 32'd0);
    check32("c_drop_req_valid", 32'(s_req_valid), 32'd0);
    run(5);
    check32("c_nreq", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check32("c_req0", req_log[0], 32'h100);
    check32("c_npop", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) check32("c_pop0", pop_log[0], 32'h100);

    // Redirect coinciding with a response
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    run(1);
    clear_logs();
    drv_redirect = 1'b1; drv_tgt = 32'h0000_0040;
    run(1);
    drv_redirect = 1'b0;
    run(1);
    check32("d_req_valid", 32'(s_req_valid), 32'd1);
    check32("d_req_addr", s_req_addr, 32'h40);
    check32("d_if_valid", 32'(s_if_valid), 32'd0);
    check32("d_npop", pop_log.size(), 0);

    // Fetch PC wrap at the top of the address space
    do_reset();
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    clear_logs();
    drv_redirect = 1'b1; drv_tgt = 32'hFFFF_FFFE;
    run(1);
    drv_redirect = 1'b0;
    run(4);
    check32("e_nreq", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      check32("e_req0", req_log[0], 32'hFFFF_FFFC);
      check32("e_req1", req_log[1], 32'h0000_0000);
    end

    // Reset with a request outstanding; late response after release
    do_reset();
    lat_min = 5; lat_max = 5;
    drv_ready = 1'b1; drv_id_ready = 1'b1;
    run(1);
    do_reset();
    drv_ready = 1'b0; drv_id_ready = 1'b1;
    run(1);
    check32("f_req_valid", 32'(s_req_valid), 32'd1);
    check32("f_req_addr", s_req_addr, RESET_PC);
    drv_stale = 1'b1;
    run(1);
    drv_stale = 1'b0;
    run(1);
    check32("f_if_valid", 32'(s_if_valid), 32'd0);
    lat_min = 1; lat_max = 3;
    drv_ready = 1'b1;
    run(4);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      drv_ready    = ($urandom_range(0, 3) != 0);
      drv_id_ready = ($urandom_range(0, 9) < 7);
      drv_redirect = ($urandom_range(0, 11) == 0);
      drv_tgt      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
